eep_i2c_master: RTL and testbench

//  Byte-level I2C initiator: drives SCL/SDA toward an I2C responder, such as the
//  eep_24cXX_sync EEPROM model, from simple commands.

---
 rtl/eep_i2c_master.sv | 191 +++++++++++++++++++
 tb/tb_eep_i2c_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eep_i2c_master.sv
// rtl/eep_i2c_master.sv - byte-level I2C initiator driving SCL/SDA from START/STOP/WRITE/READ commands
module eep_i2c_master #(
  parameter int QDIV = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] wr_data,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       nack,
  output logic       scl,
  output logic       sda_out,
  input  logic       sda_in
);

  localparam int CW = $clog2(QDIV);
  localparam logic [CW-1:0] QLAST = CW'(QDIV - 1);

  // The one-clock DONE step is folded into IDLE: rsp_valid is raised on the
  // transition back to IDLE so a new command can be accepted in that same clk.
  typedef enum logic [1:0] {S_IDLE, S_START, S_STOP, S_BYTE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic          rd_op_q, rd_op_d;
  logic          ack_low_q, ack_low_d;
  logic [7:0]    sh_q, sh_d;
  logic          samp_q, samp_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          nack_q, nack_d;
  logic          q_end;

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rd_data   = rd_data_q;
  assign nack      = nack_q;
  assign scl       = scl_q;
  assign sda_out   = sda_q;

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    rd_op_d     = rd_op_q;
    ack_low_d   = ack_low_q;
    sh_d        = sh_q;
    samp_d      = samp_q;
    scl_d       = scl_q;
    sda_d       = sda_q;
    rsp_valid_d = 1'b0;
    rd_data_d   = rd_data_q;
    nack_d      = nack_q;
    q_end       = (qcnt_q == QLAST);

    if (state_q != S_IDLE) begin
      qcnt_d = q_end ? '0 : qcnt_q + 1'b1;
      if (q_end) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          qcnt_d = '0;
          qtr_d  = 2'd0;
          bit_d  = 4'd0;
          case (cmd)
            3'd0: begin state_d = S_START; scl_d = 1'b0; sda_d = 1'b1; end
            3'd1: begin state_d = S_STOP;  scl_d = 1'b0; sda_d = 1'b0; end
            3'd2: begin
              state_d = S_BYTE;
              rd_op_d = 1'b0;
              sh_d    = wr_data;
              scl_d   = 1'b0;
              sda_d   = wr_data[7];
            end
            3'd4, 3'd5: begin
              state_d   = S_BYTE;
              rd_op_d   = 1'b1;
              ack_low_d = ~cmd[0];
              sh_d      = 8'h00;
              scl_d     = 1'b0;
              sda_d     = 1'b1;
            end
            default: rsp_valid_d = 1'b1;
          endcase
        end
      end
      S_START: begin
        if (q_end) begin
          case (qtr_q)
            2'd0:    {scl_d, sda_d} = 2'b11;
            2'd1:    {scl_d, sda_d} = 2'b10;
            2'd2:    {scl_d, sda_d} = 2'b00;
            default: begin state_d = S_IDLE; rsp_valid_d = 1'b1; end
          endcase
        end
      end
      S_STOP: begin
        if (q_end) begin
          case (qtr_q)
            2'd0:    {scl_d, sda_d} = 2'b10;
            2'd1:    {scl_d, sda_d} = 2'b11;
            2'd2:    {scl_d, sda_d} = 2'b11;
            default: begin state_d = S_IDLE; rsp_valid_d = 1'b1; end
          endcase
        end
      end
      S_BYTE: begin
        if (q_end) begin
          case (qtr_q)
            2'd1: scl_d = 1'b1;
            2'd2: begin
              samp_d = sda_in;
              if (rd_op_q && bit_q != 4'd8) sh_d = {sh_q[6:0], sda_in};
            end
            2'd3: begin
              if (bit_q == 4'd8) begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                scl_d       = 1'b0;
                sda_d       = 1'b1;
                if (rd_op_q) begin
                  rd_data_d = sh_q;
                  nack_d    = 1'b0;
                end else begin
                  nack_d = samp_q;
                end
              end else begin
                bit_d = bit_q + 4'd1;
                scl_d = 1'b0;
                // Write data leaves from sh_q[7]; shifting at bit start keeps the next bit there.
                if (bit_q == 4'd7) begin
                  sda_d = rd_op_q ? ~ack_low_q : 1'b1;
                end else if (rd_op_q) begin
                  sda_d = 1'b1;
                end else begin
                  sda_d = sh_q[6];
                  sh_d  = {sh_q[6:0], 1'b0};
                end
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      qtr_q       <= 2'd0;
      bit_q       <= 4'd0;
      rd_op_q     <= 1'b0;
      ack_low_q   <= 1'b0;
      sh_q        <= 8'h00;
      samp_q      <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rd_data_q   <= 8'h00;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      rd_op_q     <= rd_op_d;
      ack_low_q   <= ack_low_d;
      sh_q        <= sh_d;
      samp_q      <= samp_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      rsp_valid_q <= rsp_valid_d;
      rd_data_q   <= rd_data_d;
      nack_q      <= nack_d;
    end
  end

endmodule

// File: tb/tb_eep_i2c_master.sv
// tb/tb_eep_i2c_master.sv - scoreboard bench for eep_i2c_master with a bit-level responder model
module tb_eep_i2c_master;
  localparam int QDIV     = 4;
  localparam int BIT_LAT  = 4 * QDIV + 1;
  localparam int BYTE_LAT = 36 * QDIV + 1;
  localparam int HIST     = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd = 3'd7;
  logic [7:0] wr_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rd_data;
  logic       nack;
  logic       scl;
  logic       sda_out;
  logic       sda_in;

  eep_i2c_master #(.QDIV(QDIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rd_data   (rd_data),
    .nack      (nack),
    .scl       (scl),
    .sda_out   (sda_out),
    .sda_in    (sda_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] c;
    logic [7:0] d;
    logic [7:0] rd;
    logic       nk;
    int         lat;
    int         acc;
    logic [1:0] prev;
  } item_t;

  item_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [1:0] line_hist [0:HIST-1];

  // Responder: per byte it drives one bit per SCL high phase, bit 0 first.
  logic [8:0] resp_pat = 9'h1FF;
  int         resp_gen = 0;
  int         r_gen = 0;
  int         r_idx = 9;
  logic       drv = 1'b1;
  logic       prev_scl = 1'b1;
  assign sda_in = sda_out & drv;

  // Reference model of the bus-visible state.
  logic [7:0] m_rd = 8'h00;
  logic       m_nk = 1'b0;
  logic [1:0] m_lines = 2'b11;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {scl,sda_out} t clocks after the accept clock.
  function automatic logic [1:0] exp_line(input logic [2:0] c, input logic [7:0] d,
                                          input int t, input logic [1:0] prev);
    int q, bn, qt;
    logic s;
    q = (t - 1) / QDIV;
    case (c)
      3'd0: begin
        case (q)
          0: return 2'b01;
          1: return 2'b11;
          2: return 2'b10;
          default: return 2'b00;
        endcase
      end
      3'd1: begin
        case (q)
          0: return 2'b00;
          1: return 2'b10;
          default: return 2'b11;
        endcase
      end
      3'd2, 3'd4, 3'd5: begin
        if (t > 36 * QDIV) return 2'b01;
        bn = q / 4;
        qt = q % 4;
        if (c == 3'd2) s = (bn < 8) ? d[7 - bn] : 1'b1;
        else           s = (bn < 8) ? 1'b1 : (c == 3'd5);
        return {(qt >= 2), s};
      end
      default: return prev;
    endcase
  endfunction

  always @(negedge clk) begin
    item_t it;
    int bad;
    logic [1:0] e;
    line_hist[cyc % HIST] = {scl, sda_out};
    if (rst) begin
      r_idx = 9;
      drv   = 1'b1;
    end else begin
      if (resp_gen != r_gen) begin
        r_gen = resp_gen;
        r_idx = 0;
      end
      if (scl && !prev_scl && r_idx < 9) begin
        drv = resp_pat[r_idx];
        r_idx++;
      end else if (!scl && prev_scl) begin
        drv = 1'b1;
      end
    end
    prev_scl = scl;

    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 with no command outstanding (cycle %0d)", cyc);
      end else begin
        it = exp_q.pop_front();
        chk("latency", cyc - it.acc, it.lat);
        chk("rd_data", {24'd0, rd_data}, {24'd0, it.rd});
        chk("nack", {31'd0, nack}, {31'd0, it.nk});
        bad = -1;
        e   = 2'b00;
        for (int t = 1; t <= it.lat; t++) begin
          if (bad < 0 && line_hist[(it.acc + t) % HIST] !== exp_line(it.c, it.d, t, it.prev)) begin
            bad = t;
            e   = exp_line(it.c, it.d, t, it.prev);
          end
        end
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL bus_trace cmd=%0d clk %0d after accept: got {scl,sda}=%b expected %b",
                   it.c, bad, line_hist[(it.acc + bad) % HIST], e);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] c, input logic [7:0] d,
                          input logic [7:0] rbyte, input logic rack);
    item_t it;
    it.c    = c;
    it.d    = d;
    it.acc  = cyc;
    it.prev = m_lines;
    case (c)
      3'd0: begin it.lat = BIT_LAT; m_lines = 2'b00; end
      3'd1: begin it.lat = BIT_LAT; m_lines = 2'b11; end
      3'd2: begin
        it.lat   = BYTE_LAT;
        m_nk     = rack;
        m_lines  = 2'b01;
        resp_pat = {rack, 8'hFF};
        resp_gen++;
      end
      3'd4, 3'd5: begin
        it.lat  = BYTE_LAT;
        m_rd    = rbyte;
        m_nk    = 1'b0;
        m_lines = 2'b01;
        for (int k = 0; k < 8; k++) resp_pat[k] = rbyte[7 - k];
        resp_pat[8] = 1'b1;
        resp_gen++;
      end
      default: it.lat = 1;
    endcase
    it.rd = m_rd;
    it.nk = m_nk;
    exp_q.push_back(it);
  endtask

  task automatic wait_ready(output logic ok);
    int w;
    w = 0;
    while (!cmd_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    ok = cmd_ready;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cmd_ready stayed 0 for %0d clk", w);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d,
                       input logic [7:0] rbyte, input logic rack);
    logic ok;
    wait_ready(ok);
    if (ok) begin
      cmd_valid = 1'b1;
      cmd       = c;
      wr_data   = d;
      push_exp(c, d, rbyte, rack);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 3'($urandom);
      wr_data   = 8'($urandom);
    end
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic [2:0] pick [0:7];
    int busy_ready;
    int w;
    pick[0] = 3'd0; pick[1] = 3'd1; pick[2] = 3'd2; pick[3] = 3'd4;
    pick[4] = 3'd5; pick[5] = 3'd3; pick[6] = 3'd6; pick[7] = 3'd7;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_scl", {31'd0, scl}, 32'd1);
    chk("reset_sda", {31'd0, sda_out}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rd_data", {24'd0, rd_data}, 32'd0);
    chk("reset_nack", {31'd0, nack}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // No responder: address byte goes unacknowledged.
    issue(3'd0, 8'h00, 8'h00, 1'b0);
    issue(3'd2, 8'hA0, 8'h00, 1'b1);
    issue(3'd2, 8'h05, 8'h00, 1'b0);
    issue(3'd0, 8'h00, 8'h00, 1'b0);
    issue(3'd5, 8'h00, 8'h3C, 1'b0);
    issue(3'd7, 8'h00, 8'h00, 1'b0);
    issue(3'd4, 8'h00, 8'hA5, 1'b0);
    issue(3'd1, 8'h00, 8'h00, 1'b0);
    issue(3'd3, 8'h00, 8'h00, 1'b0);

    // cmd_valid held through a WRITE while cmd/wr_data churn.
    wait_ready(ok);
    if (ok) begin
      cmd_valid = 1'b1;
      cmd       = 3'd2;
      wr_data   = 8'h5A;
      push_exp(3'd2, 8'h5A, 8'h00, 1'b0);
      busy_ready = 0;
      for (int t = 1; t <= 36 * QDIV; t++) begin
        @(negedge clk);
        if (cmd_ready) busy_ready++;
        cmd     = 3'($urandom);
        wr_data = 8'($urandom);
      end
      @(negedge clk);
      chk("held_ready_at_rsp", {31'd0, cmd_ready}, 32'd1);
      chk("held_rsp_with_ready", {31'd0, rsp_valid}, 32'd1);
      cmd = 3'd7;
      push_exp(3'd7, wr_data, 8'h00, 1'b0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("held_busy_ready_cycles", busy_ready, 32'd0);
    end

    // Reset in the middle of bit 4 of a WRITE that would set nack.
    issue(3'd2, 8'hC3, 8'h00, 1'b1);
    repeat (16 * QDIV + 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_scl", {31'd0, scl}, 32'd1);
    chk("abort_sda", {31'd0, sda_out}, 32'd1);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    m_rd    = 8'h00;
    m_nk    = 1'b0;
    m_lines = 2'b11;
    repeat (40 * QDIV) @(negedge clk);
    chk("abort_nack", {31'd0, nack}, 32'd0);
    chk("abort_rd_data", {24'd0, rd_data}, 32'd0);

    for (int n = 0; n < 30; n++) begin
      issue(pick[$urandom_range(0, 7)], 8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses missing", exp_q.size());
    end
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
